// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm_if
//  Purpose  : Bundles the multicycle controller's datapath-facing signals.
//             The master (controller) drives the controls; the slave
//             (datapath/memory/MDU side) drives the decode and handshake
//             inputs.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_fsm_if #(
  parameter int ALUOP_W = 2
);
  logic [6:0]         opcode;
  logic [6:0]         fetch_opcode;
  logic [6:0]         funct7;
  logic               mem_ready;
  logic               mdu_done;

  logic               PC_write_cond;
  logic               PC_write;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               IR_write;
  logic               PC_source;
  logic               ALU_src_a;
  logic               reg_write;
  logic [1:0]         ALU_src_b;
  logic [ALUOP_W-1:0] ALU_op;
  logic               mem_req;
  logic               mdu_start;
  logic               mdu_to_reg;
  logic               is_ecall;
  logic               trap;
  logic [3:0]         state_dbg;

  modport master (
    input  opcode, fetch_opcode, funct7, mem_ready, mdu_done,
    output PC_write_cond, PC_write, i_or_d, mem_read, mem_write, mem_to_reg,
           IR_write, PC_source, ALU_src_a, reg_write, ALU_src_b, ALU_op,
           mem_req, mdu_start, mdu_to_reg, is_ecall, trap, state_dbg
  );

  modport slave (
    output opcode, fetch_opcode, funct7, mem_ready, mdu_done,
    input  PC_write_cond, PC_write, i_or_d, mem_read, mem_write, mem_to_reg,
           IR_write, PC_source, ALU_src_a, reg_write, ALU_src_b, ALU_op,
           mem_req, mdu_start, mdu_to_reg, is_ecall, trap, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Multicycle RV32 control FSM with variable-latency memory
//             handshake and timeout, multi-cycle MUL/DIV path, sticky HALT
//             on ECALL and sticky TRAP on illegal opcode or memory timeout.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int MDU_EN      = 1,
  parameter int ALUOP_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ARITH  = 7'b0110011;
  localparam logic [6:0] OPC_ARITHI = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_ECALL  = 7'b1110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [ALUOP_W-1:0] ALUOP_BR = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALUOP_FN = ALUOP_W'(2);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,  S_MEM_WB   = 4'd4,  S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,  S_RCOMPL   = 4'd7,  S_BRANCH   = 4'd8,
    S_HALT     = 4'd9,  S_EXEC_IMM = 4'd10, S_JAL      = 4'd11,
    S_JALR     = 4'd12, S_MDU_WAIT = 4'd13, S_TRAP     = 4'd14
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               first_q;     // current cycle is the first one in state_q
  logic               mdu_sel_q;   // previous state was MDU_WAIT

  logic               pc_write_cond, pc_write, i_or_d, mem_read, mem_write;
  logic               mem_to_reg, ir_write, pc_source, alu_src_a, reg_write;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               mem_req, mdu_start, mdu_to_reg, is_ecall, trap;
  logic               timeout;

  // Timeout fires only while a request is outstanding and unanswered this cycle.
  assign timeout = mem_req && !bus.mem_ready && (wait_q == CNT_W'(MEM_TIMEOUT));

  // State, wait counter and entry/MDU bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      first_q   <= 1'b1;
      mdu_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      first_q   <= (state_d != state_q);
      mdu_sel_q <= (state_q == S_MDU_WAIT);
    end
  end

  // Next-state, per-state datapath controls and wait-counter update.
  always_comb begin
    state_d       = state_q;
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = '0;
    mem_req       = 1'b0;
    mdu_start     = 1'b0;
    mdu_to_reg    = 1'b0;
    is_ecall      = 1'b0;
    trap          = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        if (bus.mem_ready)
          state_d = (bus.fetch_opcode == OPC_JAL) ? S_JAL : S_DECODE;
        else if (timeout)
          state_d = S_TRAP;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        pc_source = 1'b1;
        case (bus.opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_ARITH: begin
            if (bus.funct7 == F7_MULDIV)
              state_d = (MDU_EN != 0) ? S_MDU_WAIT : S_TRAP;
            else
              state_d = S_EXEC;
          end
          OPC_ARITHI: state_d = S_EXEC_IMM;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_JALR:   state_d = S_JALR;
          OPC_ECALL:  state_d = S_HALT;
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready)  state_d = S_MEM_WB;
        else if (timeout)   state_d = S_TRAP;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready)  state_d = S_FETCH;
        else if (timeout)   state_d = S_TRAP;
      end
      S_EXEC, S_EXEC_IMM: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FN;
        alu_src_b = (state_q == S_EXEC_IMM) ? 2'b10 : 2'b00;
        state_d   = S_RCOMPL;
      end
      S_RCOMPL: begin
        reg_write  = 1'b1;
        mdu_to_reg = mdu_sel_q;
        state_d    = S_FETCH;
      end
      S_MDU_WAIT: begin
        mdu_start = first_q;
        if (bus.mdu_done) begin
          mdu_to_reg = 1'b1;
          state_d    = S_RCOMPL;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_BR;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALUOP_FN;
        pc_write  = 1'b1;
        state_d   = S_RCOMPL;
      end
      S_HALT:  is_ecall = 1'b1;
      S_TRAP:  trap     = 1'b1;
      default: state_d  = S_TRAP;
    endcase

    // Counter restarts on each new access and counts unanswered request cycles.
    wait_d = wait_q;
    if ((state_d != state_q) &&
        (state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR))
      wait_d = '0;
    else if (mem_req && !bus.mem_ready)
      wait_d = wait_q + CNT_W'(1);
  end

  assign bus.PC_write_cond = pc_write_cond;
  assign bus.PC_write      = pc_write;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.IR_write      = ir_write;
  assign bus.PC_source     = pc_source;
  assign bus.ALU_src_a     = alu_src_a;
  assign bus.reg_write     = reg_write;
  assign bus.ALU_src_b     = alu_src_b;
  assign bus.ALU_op        = alu_op;
  assign bus.mem_req       = mem_req;
  assign bus.mdu_start     = mdu_start;
  assign bus.mdu_to_reg    = mdu_to_reg;
  assign bus.is_ecall      = is_ecall;
  assign bus.trap          = trap;
  assign bus.state_dbg     = state_q;

endmodule
`default_nettype wire
